// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes a raw push-button level into the clk domain
// and accepts a level change only after STABLE_CYCLES consecutive identical
// samples. Produces a registered clean level plus one-cycle press/release
// strobes.
// Build option: define BUTTON_DEBOUNCE_SYNC_EN for the two-flop synchronizer;
// without it a single sampling flop is used (for already-synchronous sources).
module button_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_clean,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          clean_next;
  logic          press_next;
  logic          release_next;
  logic          s2;

`ifdef BUTTON_DEBOUNCE_SYNC_EN
  logic s1;

  // Two-flop synchronizer bringing the asynchronous button into clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end
`else
  // Single sampling flop; only safe when button is already synchronous
  always_ff @(posedge clk) begin
    if (rst) begin
      s2 <= 1'b0;
    end else begin
      s2 <= button;
    end
  end
`endif

  // State, stability counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOW;
      cnt           <= '0;
      button_clean  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      button_clean  <= clean_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  // Next-state logic: count consecutive opposite samples, abort on any reversal
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    clean_next   = button_clean;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      LOW: begin
        clean_next = 1'b0;
        if (s2) begin
          state_next = RISE;
          cnt_next   = CNT_ONE;
        end
      end
      RISE: begin
        if (!s2) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = HIGH;
          cnt_next   = '0;
          clean_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        clean_next = 1'b1;
        if (!s2) begin
          state_next = FALL;
          cnt_next   = CNT_ONE;
        end
      end
      FALL: begin
        if (s2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next   = LOW;
          cnt_next     = '0;
          clean_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
        clean_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios followed by randomized button runs,
// all checked every cycle against a history-based reference model: a change is
// accepted when the last STABLE_CYCLES samples seen by the debouncer (button
// history delayed by the sampling depth, zeroed around reset) all differ from
// the current clean level.
module tb_button_debouncer;

  localparam int S = 4;
`ifdef BUTTON_DEBOUNCE_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int LAT = S + D - 1;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic button_clean;
  logic press_pulse;
  logic release_pulse;

  button_debouncer #(.STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .button_clean (button_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int passed   = 0;
  int fail_cnt = 0;
  int cyc      = 8;
  int last_rst = 0;

  bit btn_h [0:HMAX-1];
  bit rst_h [0:HMAX-1];
  bit m_clean;
  bit m_press;
  bit m_release;

  // Level the debouncer's decision logic sees at edge k
  function automatic bit samp(input int k);
    if (D == 2) return (rst_h[k-1] || rst_h[k-2]) ? 1'b0 : btn_h[k-2];
    else        return rst_h[k-1] ? 1'b0 : btn_h[k-1];
  endfunction

  task automatic model_edge();
    bit acc;
    if (rst_h[cyc]) begin
      m_clean   = 1'b0;
      m_press   = 1'b0;
      m_release = 1'b0;
      last_rst  = cyc;
    end else begin
      acc = (cyc - S + 1 > last_rst);
      for (int k = cyc - S + 1; k <= cyc; k++)
        if (samp(k) == m_clean) acc = 1'b0;
      m_press   = acc && !m_clean;
      m_release = acc && m_clean;
      if (acc) m_clean = !m_clean;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fail_cnt++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs (optionally glitching between edges), advance,
  // update model, then compare all outputs 1 time unit after the edge
  task automatic step(input logic b, input logic r, input bit glitch);
    rst = r;
    if (glitch) begin
      button = !b; #1;
      button = b;  #1;
      button = !b; #1;
      button = b;
    end else begin
      button = b;
    end
    @(posedge clk);
    if (cyc < HMAX - 1) cyc++;
    btn_h[cyc] = b;
    rst_h[cyc] = r;
    model_edge();
    #1;
    check("button_clean", button_clean, m_clean);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_release);
  endtask

  // Hold button at b from E0 and report the edge offset of the first strobe
  task automatic measure(input logic b, input bit rel, input string tag);
    int e0;
    int got;
    e0  = cyc + 1;
    got = -1;
    for (int i = 0; i < LAT + 4; i++) begin
      step(b, 1'b0, 1'b0);
      if (got < 0 && (rel ? release_pulse : press_pulse)) got = cyc - e0;
    end
    check_int(tag, got, LAT);
  endtask

  initial begin
    int npress;
    int len;
    logic rb;
    bit rr;
    bit rg;

    // Reset held with button pressed, then press after release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    measure(1'b1, 1'b0, "reset_release_press_latency");

    // Clean release from HIGH, then clean press and release again
    measure(1'b0, 1'b1, "clean_release_latency");
    measure(1'b1, 1'b0, "clean_press_latency");
    measure(1'b0, 1'b1, "second_release_latency");

    // Bounce 1,1,1,0 must be rejected; a later stable press needs full latency
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    npress = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (press_pulse) npress++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (press_pulse || button_clean) npress++;
    end
    check_int("bounce_rejected", npress, 0);
    measure(1'b1, 1'b0, "press_after_bounce_latency");
    measure(1'b0, 1'b1, "release_after_bounce_latency");

    // Sub-cycle glitches while low at every edge
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a rising attempt
    npress = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (press_pulse || button_clean) npress++;
    end
    check_int("reset_mid_rise_no_press", npress, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    measure(1'b0, 1'b1, "release_after_mid_reset_latency");

    // Randomized runs of varying length with occasional reset and glitches
    for (int n = 0; n < 120; n++) begin
      rb  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      rr  = ($urandom_range(0, 29) == 0);
      rg  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) step(rb, rr && (i == 0), rg);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
